// File: rtl/jimmy_pkg.sv
// Shared definitions for the 8-bit CPU front end.
// Contents: opcode constants, the fetch FSM state type and the
// instruction-length rule is_two_byte(), which the fetch sequencer
// and the decoder both use.
package jimmy_pkg;

    localparam logic [5:0] OP_MOV_IMM = 6'b100000;
    localparam logic [5:0] OP_CMP_IMM = 6'b100011;
    localparam logic [7:0] OP_BRA     = 8'hA8;
    localparam logic [7:0] OP_BHI     = 8'hB0;
    localparam logic [7:0] OP_BEQ     = 8'hB4;
    localparam logic [7:0] OP_NOP     = 8'h70;

    typedef enum logic [1:0] {
        FETCH0,
        FETCH1,
        HOLD,
        IDLE
    } fetch_state_t;

    // Branches occupy the whole 101x_xxxx opcode block. MOV/CMP immediate
    // reserve the two low opcode bits for the register field.
    function automatic logic is_two_byte(input logic [7:0] opcode);
        return (opcode[7:5] == 3'b101)
            || (opcode[7:2] == OP_MOV_IMM)
            || (opcode[7:2] == OP_CMP_IMM);
    endfunction

endpackage

// File: rtl/instr_len_decode.sv
// Combinational instruction-length decode. The decoder uses the same
// module, so both sides always agree on the instruction length.
// Ports:
//   opcode   in  8  first instruction byte
//   two_byte out 1  1 = instruction carries an immediate/target byte
module instr_len_decode
    import jimmy_pkg::*;
(
    input  logic [7:0] opcode,
    output logic       two_byte
);

    assign two_byte = is_two_byte(opcode);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller. It walks the PC through asynchronous-read
// program memory, assembles 1- or 2-byte instructions and offers them to
// the decoder over a valid/ready handshake. A redirect from the branch
// unit takes priority over everything else.
// Optional feature, macro FETCH_HALT_DETECT_EN: adds a 'halted' output.
// When a BRA to its own address is accepted, fetch parks in IDLE until
// the next redirect or reset.
// Ports:
//   clk, reset (async, active low)
//   mem_addr       out  program-memory address (= PC)
//   mem_data       in   program-memory read data
//   instr_valid/instr_ready  handshake to the decoder
//   instr_byte0/instr_byte1/instr_len2/instr_pc  assembled instruction
//   redirect_valid/redirect_addr  taken-branch target
//   halted         out  (FETCH_HALT_DETECT_EN only) self-branch detected
//
// state  | meaning
// FETCH0 | read opcode byte at pc
// FETCH1 | read second byte of a 2-byte instruction
// HOLD   | instruction presented, waiting for instr_ready
// IDLE   | parked after a self-branch (halt detect builds only)
module fetch_sequencer
    import jimmy_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_byte0,
    output logic [7:0]        instr_byte1,
    output logic              instr_len2,
    output logic [ADDR_W-1:0] instr_pc,
`ifdef FETCH_HALT_DETECT_EN
    output logic              halted,
`endif
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [7:0]        byte0_nxt, byte1_nxt;
    logic              len2_nxt, valid_nxt;
    logic [ADDR_W-1:0] instr_pc_nxt;
    logic              two_byte;

    instr_len_decode u_len (
        .opcode   (mem_data),
        .two_byte (two_byte)
    );

    assign mem_addr = pc;

`ifdef FETCH_HALT_DETECT_EN
    logic halted_nxt;
`endif

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        byte0_nxt    = instr_byte0;
        byte1_nxt    = instr_byte1;
        len2_nxt     = instr_len2;
        instr_pc_nxt = instr_pc;
        valid_nxt    = instr_valid;
`ifdef FETCH_HALT_DETECT_EN
        halted_nxt   = halted;
`endif

        case (state)
            FETCH0: begin
                byte0_nxt    = mem_data;
                instr_pc_nxt = pc;
                pc_nxt       = pc + ADDR_W'(1);
                len2_nxt     = two_byte;
                if (two_byte) begin
                    state_nxt = FETCH1;
                end else begin
                    byte1_nxt = 8'h00;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end
            FETCH1: begin
                byte1_nxt = mem_data;
                pc_nxt    = pc + ADDR_W'(1);
                valid_nxt = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (instr_valid && instr_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = FETCH0;
`ifdef FETCH_HALT_DETECT_EN
                    // Self-branch: the program is spinning, so stop fetching.
                    if (instr_byte0 == OP_BRA && instr_pc == ADDR_W'(instr_byte1)) begin
                        halted_nxt = 1'b1;
                        state_nxt  = IDLE;
                    end
`endif
                end
            end
            IDLE: begin
                valid_nxt = 1'b0;
            end
        endcase

        // A redirect discards whatever is held or half-fetched; a handshake
        // in the same cycle has already completed on the decoder side.
        if (redirect_valid) begin
            pc_nxt    = redirect_addr;
            state_nxt = FETCH0;
            valid_nxt = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            halted_nxt = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH0;
            pc          <= RESET_PC;
            instr_byte0 <= 8'h00;
            instr_byte1 <= 8'h00;
            instr_len2  <= 1'b0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr_byte0 <= byte0_nxt;
            instr_byte1 <= byte1_nxt;
            instr_len2  <= len2_nxt;
            instr_pc    <= instr_pc_nxt;
            instr_valid <= valid_nxt;
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) halted <= 1'b0;
        else        halted <= halted_nxt;
    end
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the 8-bit CPU. It drives the program-memory address bus and reads 1- or 2-byte instructions from the asynchronous-read program memory.
- Each instruction is assembled into a single word and handed to the decoder over a valid/ready handshake.
- Decoder/branch-unit redirects (BRA/BHI/BEQ taken) are accepted on a dedicated port.
- Sits between program_memory and the decode/execute datapath.

Parameters:
- RESET_PC, 8'h00: fetch address loaded on reset.
- ADDR_W, 8: program address width. Memory depth is 2^ADDR_W; the PC wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_addr  out  ADDR_W  program-memory address, equal to the current PC.
- mem_data  in  8  program-memory read data, combinational from mem_addr.
- instr_valid  out  1  assembled instruction available.
- instr_ready  in  1  decoder accepts the instruction.
- instr_byte0  out  8  opcode byte.
- instr_byte1  out  8  immediate/target byte; 8'h00 for 1-byte instructions.
- instr_len2  out  1  1 = 2-byte instruction.
- instr_pc  out  ADDR_W  address of instr_byte0.
- redirect_valid  in  1  branch taken, one-cycle pulse.
- redirect_addr  in  ADDR_W  branch target.

Behaviour:
- Reset (asynchronous assert, deassert on clk): pc=RESET_PC, state=FETCH0, instr_valid=0, instr_byte0/byte1=0, instr_len2=0, instr_pc=0.
- Length rule: 2-byte if mem_data[7:5]==3'b101 (branches), or mem_data[7:2]==6'b100000 (MOV_IMM), or mem_data[7:2]==6'b100011 (CMP_IMM). All other opcodes are 1-byte.
- FETCH0:
  - At the edge: byte0<=mem_data, instr_pc<=pc, pc<=pc+1.
  - If 2-byte, go to FETCH1.
  - Otherwise byte1<=0, instr_valid<=1, go to HOLD.
- FETCH1:
  - At the edge: byte1<=mem_data, pc<=pc+1, instr_valid<=1, go to HOLD.
- HOLD:
  - Outputs stable while instr_valid=1 and instr_ready=0.
  - On valid&ready: instr_valid<=0 and go to FETCH0 at the same edge, so the next fetch starts the following cycle.
- Latency and throughput:
  - 1-byte instruction: valid 1 cycle after fetch start.
  - 2-byte instruction: valid 2 cycles after fetch start.
  - With ready held high, throughput is one instruction per 2 cycles (1-byte) or per 3 cycles (2-byte).
- Redirect has priority in every state. At the edge: pc<=redirect_addr, state<=FETCH0, instr_valid<=0. Any held or partially fetched instruction is discarded.
- Redirect in the same cycle as valid&ready: the handshake counts as completed (consumed), then the redirect applies.
- Wrap-around: pc 2^ADDR_W-1 +1 → 0. A 2-byte instruction at the last address takes byte1 from address 0.
- Reset mid-fetch: the partial instruction is lost and fetch restarts at RESET_PC.
- mem_addr = pc at all times, combinationally.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined:
  - Adds output port halted (1 bit, reset 0).
  - When a BRA (byte0==8'hA8) whose byte1 equals its own instr_pc is accepted, halted<=1 and the sequencer enters IDLE.
  - In IDLE: no fetch, instr_valid=0, mem_addr frozen.
  - Only a redirect or reset leaves IDLE; both clear halted.
- Not defined: no halted port. A self-branch is fetched repeatedly like any other instruction.

Decomposition:
- Package jimmy_pkg holds:
  - opcode constants (OP_MOV_IMM 6'b100000, OP_CMP_IMM 6'b100011, OP_BRA 8'hA8, OP_BHI 8'hB0, OP_BEQ 8'hB4, OP_NOP 8'h70);
  - typedef enum fetch_state_t {FETCH0, FETCH1, HOLD, IDLE};
  - function is_two_byte(byte).
- One sub-module, instr_len_decode: a combinational wrapper around is_two_byte, shared with the decoder.

Test Plan:
- Reset release, memory {0x81,0x00,0x98}, ready=1:
  - cycle 2: valid, byte0=0x81, byte1=0x00, len2=1, pc=0;
  - cycle 4: byte0=0x98, len2=0, pc=2.
- Backpressure: ready=0 for 5 cycles while valid → outputs and mem_addr unchanged. Ready high → exactly one acceptance, then mem_addr=3 fetched.
- Redirect pulse to 0x04 during FETCH1 of the instruction at 0x07 → no valid for 0x07; the next instruction has pc=0x04.
- Redirect coinciding with valid&ready → the instruction is counted once; the next instruction is fetched from redirect_addr.
- Wrap: 0x81 at 0xFF, 0x2A at 0x00 → byte1=0x2A, len2=1, then mem_addr=0x01.
- FETCH_HALT_DETECT_EN: {0xA8,0x0F} at 0x0F, accepted → halted=1, valid stays 0, mem_addr frozen. Redirect to 0x00 → halted=0, fetch resumes.
